// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the CPU on-chip memory stream loader.
// State encoding plus the geometry of the 1024x32 target memory.
package cpu_loader_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int MEM_WORDS      = 2 ** DEF_ADDR_W;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cpu_mem_stream_loader_if.sv
// Byte-stream sink plus Avalon-MM write port bundle of the memory loader.
// master = loader side, slave = stream source / memory side.
interface cpu_mem_stream_loader_if
  import cpu_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic [7:0]                  s_data;
  logic                        s_valid;
  logic                        s_ready;
  logic                        s_last;
  logic [ADDR_W-1:0]           m_address;
  logic [BYTES_PER_WORD-1:0]   m_byteenable;
  logic                        m_chipselect;
  logic                        m_write;
  logic [8*BYTES_PER_WORD-1:0] m_writedata;
  logic                        m_clken;

  modport master (
    input  s_data, s_valid, s_last,
    output s_ready, m_address, m_byteenable, m_chipselect, m_write,
           m_writedata, m_clken
  );

  modport slave (
    output s_data, s_valid, s_last,
    input  s_ready, m_address, m_byteenable, m_chipselect, m_write,
           m_writedata, m_clken
  );

endinterface

// File: rtl/cpu_loader_packer.sv
// Little-endian byte-to-word packer: lane index, lane insertion, byteenable
// accumulation and the "last byte seen" marker for the word being built.
module cpu_loader_packer
  import cpu_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        accept,
  input  logic [7:0]                  byte_in,
  input  logic                        last_in,
  output logic [8*BYTES_PER_WORD-1:0] word,
  output logic [BYTES_PER_WORD-1:0]   be,
  output logic                        word_full,
  output logic                        word_last
);

  logic [1:0] idx;

  // The byte being accepted now completes the word.
  assign word_full = (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      word      <= '0;
      be        <= '0;
      word_last <= 1'b0;
    end else if (clear) begin
      idx       <= '0;
      word      <= '0;
      be        <= '0;
      word_last <= 1'b0;
    end else if (accept) begin
      word[8*idx +: 8] <= byte_in;
      be[idx]          <= 1'b1;
      word_last        <= last_in;
      idx              <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/cpu_mem_stream_loader.sv
// Loads a byte stream into the CPU on-chip memory as packed 32-bit words.
// FSM, address counter, word count, checksum and overflow live here.
module cpu_mem_stream_loader
  import cpu_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  cpu_mem_stream_loader_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [ADDR_W:0]      word_count,
  output logic [15:0]          checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   WC_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  state_e                      state;
  logic                        s_ready_r;
  logic [ADDR_W-1:0]           addr_r;
  logic                        cs_r;
  logic                        wr_r;
  logic                        clken_r;

  logic                        accept;
  logic                        pk_accept;
  logic                        pk_clear;
  logic [8*BYTES_PER_WORD-1:0] pk_word;
  logic [BYTES_PER_WORD-1:0]   pk_be;
  logic                        pk_full;
  logic                        pk_last;

  assign accept    = bus.s_valid & s_ready_r;
  assign pk_accept = accept && (state == ST_COLLECT);
  // The word is cleared when a load begins and on the edge that ends WRITE.
  assign pk_clear  = ((state == ST_IDLE) && start) || (state == ST_WRITE);

  cpu_loader_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (pk_clear),
    .accept    (pk_accept),
    .byte_in   (bus.s_data),
    .last_in   (bus.s_last),
    .word      (pk_word),
    .be        (pk_be),
    .word_full (pk_full),
    .word_last (pk_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      s_ready_r  <= 1'b0;
      addr_r     <= '0;
      cs_r       <= 1'b0;
      wr_r       <= 1'b0;
      clken_r    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      checksum   <= '0;
    end else begin
      clken_r <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_r     <= start_addr;
            word_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            s_ready_r  <= 1'b1;
            state      <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            checksum <= checksum + {8'd0, bus.s_data};
            if (pk_full || bus.s_last) begin
              s_ready_r <= 1'b0;
              cs_r      <= 1'b1;
              wr_r      <= 1'b1;
              state     <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          cs_r       <= 1'b0;
          wr_r       <= 1'b0;
          word_count <= word_count + WC_ONE;
          if (pk_last) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (addr_r == LAST_ADDR) begin
            // Memory is full: keep the address, swallow the rest of the image.
            overflow  <= 1'b1;
            s_ready_r <= 1'b1;
            state     <= ST_DRAIN;
          end else begin
            addr_r    <= addr_r + 1'b1;
            s_ready_r <= 1'b1;
            state     <= ST_COLLECT;
          end
        end
        ST_DRAIN: begin
          if (accept && bus.s_last) begin
            s_ready_r <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_ready      = s_ready_r;
  assign bus.m_address    = addr_r;
  assign bus.m_byteenable = pk_be;
  assign bus.m_chipselect = cs_r;
  assign bus.m_write      = wr_r;
  assign bus.m_writedata  = pk_word;
  assign bus.m_clken      = clken_r;

endmodule

// File: tb/tb_cpu_mem_stream_loader.sv
// Directed bench for cpu_mem_stream_loader with a write scoreboard fed by a
// byte-level packing model.
module tb_cpu_mem_stream_loader;
  import cpu_loader_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW:0]   word_count;
  logic [15:0]   checksum;

  cpu_mem_stream_loader_if #(.ADDR_W(AW)) bus ();

  cpu_mem_stream_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  // Scoreboard entries: {address, byteenable, writedata}
  logic [45:0] exp_q[$];

  // Packing model
  logic [31:0] md;
  logic [3:0]  mbe;
  int          midx;
  logic [9:0]  maddr;
  bit          mdrain;
  logic [15:0] mcs;
  int          mwc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [45:0] e;
    if (bus.m_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 64'(bus.m_write), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("write", 64'({bus.m_address, bus.m_byteenable, bus.m_writedata}), 64'(e));
        check("chipselect", 64'(bus.m_chipselect), 64'd1);
      end
    end
  end

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic model_start(input logic [9:0] a);
    maddr = a; md = '0; mbe = '0; midx = 0; mdrain = 0; mcs = '0; mwc = 0;
  endtask

  task automatic model_accept(input logic [7:0] b, input logic last);
    if (!mdrain) begin
      md[8*midx +: 8] = b;
      mbe[midx] = 1'b1;
      mcs = mcs + {8'd0, b};
      midx++;
      if (midx == 4 || last) begin
        exp_q.push_back({maddr, mbe, md});
        mwc++;
        md = '0; mbe = '0; midx = 0;
        if (!last) begin
          if (maddr == 10'(MEM_WORDS - 1)) mdrain = 1;
          else maddr = maddr + 10'd1;
        end
      end
    end
  endtask

  // Entered and left at a falling edge.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    bit ok;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_data  = b;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.s_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("s_ready_timeout", 64'(bus.s_ready), 64'd1);
    end else begin
      @(posedge clk);
      model_accept(b, last);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] a);
    model_start(a);
    done_cnt   = 0;
    start_addr = a;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic finish_load(input string tag, input logic exp_ovf);
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    check({tag, "_busy_low"},   64'(busy), 64'd0);
    check({tag, "_done_pulse"}, 64'(done_cnt), 64'd1);
    check({tag, "_word_count"}, 64'(word_count), 64'(mwc));
    check({tag, "_checksum"},   64'(checksum), 64'(mcs));
    check({tag, "_overflow"},   64'(overflow), 64'(exp_ovf));
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check(tag, 64'({bus.s_ready, bus.m_address, bus.m_byteenable, bus.m_chipselect,
                    bus.m_write, bus.m_writedata, busy, done, overflow}), 64'd0);
    check({tag, "_cnt"}, 64'({word_count, checksum}), 64'd0);
    check({tag, "_clken"}, 64'(bus.m_clken), 64'd1);
  endtask

  logic [7:0] img[6];

  initial begin
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    reset_n = 1'b0; start = 1'b0; start_addr = '0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    model_start(10'd0);
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Stream activity in IDLE is ignored
    bus.s_valid = 1'b1; bus.s_last = 1'b1; bus.s_data = 8'hEE;
    repeat (2) @(negedge clk);
    check("idle_s_ready", 64'(bus.s_ready), 64'd0);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;

    // Partial final word
    do_start(10'h010);
    check("collect_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 6; i++) send_byte(img[i], i == 5, 0);
    finish_load("partial", 1'b0);
    check("partial_cs_const", 64'(checksum), 64'h0165);

    // Backpressure gaps
    do_start(10'h010);
    for (int i = 0; i < 6; i++) send_byte(img[i], i == 5, int'($urandom_range(0, 3)));
    finish_load("gaps", 1'b0);
    check("gaps_wc_const", 64'(word_count), 64'd2);

    // Overflow and drain
    do_start(10'(MEM_WORDS - 1));
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8, 0);
    finish_load("ovf", 1'b1);
    check("ovf_addr_hold", 64'(bus.m_address), 64'h3FF);
    check("ovf_cs_const", 64'(checksum), 64'h000A);

    // Reset mid-word
    do_start(10'h055);
    send_byte(8'hC1, 1'b0, 0);
    send_byte(8'hC2, 1'b0, 0);
    reset_n = 1'b0;
    #1;
    check_reset_state("midword_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_start(10'h000);
    send_byte(8'hA5, 1'b1, 0);
    finish_load("single", 1'b0);

    // Start while busy, last on 4th byte
    do_start(10'h020);
    send_byte(8'hDE, 1'b0, 0);
    send_byte(8'hAD, 1'b0, 0);
    start_addr = 10'h100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored", 64'(bus.m_address), 64'h020);
    send_byte(8'hBE, 1'b0, 0);
    send_byte(8'hEF, 1'b1, 0);
    finish_load("last4", 1'b0);
    check("last4_wc_const", 64'(word_count), 64'd1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
